// File: rtl/dither_scan_ctrl.sv
// dither_scan_ctrl: VGA raster sequencer that fetches pixels ahead of display and feeds the dithering channels
module dither_scan_ctrl #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP = 33,
  parameter int FETCH_LEAD = 2,
  parameter int CNT_W = 10,
  parameter int ADDR_W = 19,
  parameter logic [23:0] UNDERRUN_RGB = 24'h0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  output logic              px_req,
  output logic [ADDR_W-1:0] px_addr,
  input  logic              px_valid,
  input  logic [23:0]       px_data,
  output logic [7:0]        dith_r,
  output logic [7:0]        dith_g,
  output logic [7:0]        dith_b,
  output logic              dith_visible,
  output logic              hsync,
  output logic              vsync,
  output logic [CNT_W-1:0]  hcount,
  output logic [CNT_W-1:0]  vcount,
  output logic              frame_start,
  output logic              underrun
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  typedef enum logic {IDLE, RUN} state_t;
  state_t r_state;
  logic [CNT_W-1:0] r_hf, r_vf, r_hd, r_vd;
  logic [ADDR_W-1:0] r_addr;
  logic w_hf_end, w_vf_end, w_hd_end, w_vd_end, w_wrap, w_vis, w_hs, w_vs;
  assign w_hf_end = r_hf == CNT_W'(H_TOTAL - 1);
  assign w_vf_end = r_vf == CNT_W'(V_TOTAL - 1);
  assign w_hd_end = r_hd == CNT_W'(H_TOTAL - 1);
  assign w_vd_end = r_vd == CNT_W'(V_TOTAL - 1);
  assign w_wrap = w_hf_end && w_vf_end;
  assign w_vis = r_hd < CNT_W'(H_ACTIVE) && r_vd < CNT_W'(V_ACTIVE);
  assign w_hs = r_hd >= CNT_W'(H_ACTIVE + H_FP) && r_hd < CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  assign w_vs = r_vd >= CNT_W'(V_ACTIVE + V_FP) && r_vd < CNT_W'(V_ACTIVE + V_FP + V_SYNC);
  // the address is a running request count, so it tracks raster order without a multiplier
  assign px_req = r_state == RUN && r_hf < CNT_W'(H_ACTIVE) && r_vf < CNT_W'(V_ACTIVE);
  assign px_addr = px_req ? r_addr : '0;
  // sequencer: display counters trail fetch counters by FETCH_LEAD so returning data lines up with its position
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_hf <= '0;
      r_vf <= '0;
      r_hd <= '0;
      r_vd <= '0;
      r_addr <= '0;
      {dith_r, dith_g, dith_b} <= '0;
      dith_visible <= 1'b0;
      hsync <= 1'b1;
      vsync <= 1'b1;
      hcount <= '0;
      vcount <= '0;
      frame_start <= 1'b0;
      underrun <= 1'b0;
    end else if (r_state == IDLE) begin
      {dith_r, dith_g, dith_b} <= '0;
      dith_visible <= 1'b0;
      hsync <= 1'b1;
      vsync <= 1'b1;
      hcount <= '0;
      vcount <= '0;
      frame_start <= 1'b0;
      if (enable) begin
        r_state <= RUN;
        r_hf <= '0;
        r_vf <= '0;
        r_hd <= CNT_W'(H_TOTAL - FETCH_LEAD);
        r_vd <= CNT_W'(V_TOTAL - 1);
        r_addr <= '0;
      end
    end else begin
      r_hf <= w_hf_end ? '0 : r_hf + 1'b1;
      r_vf <= w_hf_end ? (w_vf_end ? '0 : r_vf + 1'b1) : r_vf;
      r_hd <= w_hd_end ? '0 : r_hd + 1'b1;
      r_vd <= w_hd_end ? (w_vd_end ? '0 : r_vd + 1'b1) : r_vd;
      r_addr <= w_wrap ? '0 : r_addr + ADDR_W'(px_req);
      if (w_wrap && !enable) r_state <= IDLE;
      {dith_r, dith_g, dith_b} <= w_vis ? (px_valid ? px_data : UNDERRUN_RGB) : 24'h0;
      dith_visible <= w_vis;
      hsync <= !w_hs;
      vsync <= !w_vs;
      hcount <= r_hd;
      vcount <= r_vd;
      frame_start <= r_hd == '0 && r_vd == '0;
      if (w_vis && !px_valid) underrun <= 1'b1;
    end
  end
endmodule

// File: tb/tb_dither_scan_ctrl.sv
// tb_dither_scan_ctrl: scoreboard bench on a 14x7 raster with a 2-cycle pixel source
module tb_dither_scan_ctrl;
  logic clk = 0, rst = 1, enable = 0;
  logic px_req, px_valid = 0, dith_visible, hsync, vsync, frame_start, underrun;
  logic [18:0] px_addr;
  logic [23:0] px_data = 0;
  logic [7:0] dith_r, dith_g, dith_b;
  logic [9:0] hcount, vcount;
  int total = 0, bad = 0;
  int q_addr[$];
  int q_pa[$];
  logic [23:0] q_rgb[$];
  int n_req = 0, n_vis = 0, n_hs = 0, n_vs = 0, n_vsbad = 0, n_fs = 0, n_u0 = 0;
  int s_req, s_vis, s_hs, s_vs, s_vsbad, s_fs, s_u0;
  logic sup = 0, d_v = 0;
  logic [18:0] d_a = 0;

  dither_scan_ctrl #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2), .V_ACTIVE(4), .V_FP(1),
    .V_SYNC(1), .V_BP(1), .FETCH_LEAD(2), .CNT_W(10), .ADDR_W(19), .UNDERRUN_RGB(24'h0)) dut (
    .clk(clk), .rst(rst), .enable(enable), .px_req(px_req), .px_addr(px_addr),
    .px_valid(px_valid), .px_data(px_data), .dith_r(dith_r), .dith_g(dith_g), .dith_b(dith_b),
    .dith_visible(dith_visible), .hsync(hsync), .vsync(vsync), .hcount(hcount), .vcount(vcount),
    .frame_start(frame_start), .underrun(underrun));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    d_v <= px_req;
    d_a <= px_addr;
    px_valid <= d_v && !(sup && d_a == 19'd5);
    px_data <= {3{d_a[7:0]}};
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic push_frame(input bit s5);
    for (int a = 0; a < 32; a++) begin
      q_addr.push_back(a);
      q_pa.push_back(a);
      q_rgb.push_back((s5 && a == 5) ? 24'h0 : {3{8'(a)}});
    end
  endtask

  always @(negedge clk) begin
    n_req += int'(px_req);
    n_vis += int'(dith_visible);
    n_hs += int'(!hsync);
    n_vs += int'(!vsync);
    n_vsbad += int'(!vsync != (vcount == 10'd5));
    n_fs += int'(frame_start);
    n_u0 += int'(!underrun);
    if (px_req) begin
      if (q_addr.size() == 0) check("unexpected_req", 1, 0);
      else check("req_addr", 32'(px_addr), q_addr.pop_front());
    end
    if (dith_visible) begin
      if (q_pa.size() == 0) check("unexpected_visible", 1, 0);
      else begin
        int a;
        logic [23:0] rgb;
        a = q_pa.pop_front();
        rgb = q_rgb.pop_front();
        check("pix_rgb", 32'({dith_r, dith_g, dith_b}), 32'(rgb));
        check("pix_hcount", 32'(hcount), a % 8);
        check("pix_vcount", 32'(vcount), a / 8);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic snap();
    s_req = n_req; s_vis = n_vis; s_hs = n_hs; s_vs = n_vs; s_vsbad = n_vsbad; s_fs = n_fs; s_u0 = n_u0;
  endtask

  task automatic start_frame(input bit s5);
    int n;
    push_frame(s5);
    enable = 1;
    cyc(1);
    s_req = n_req;
    check("first_req", 32'(px_req), 1);
    check("first_addr", 32'(px_addr), 0);
    cyc(3);
    s_vis = n_vis; s_hs = n_hs; s_vs = n_vs; s_vsbad = n_vsbad; s_fs = n_fs;
    check("t3_frame_start", 32'(frame_start), 1);
    check("t3_visible", 32'(dith_visible), 1);
    check("t3_dith_r", 32'(dith_r), 0);
    cyc(4);
    check("last_req_line0", 32'(px_req), 1);
    check("last_addr_line0", 32'(px_addr), 7);
    n = 0;
    repeat (6) begin
      cyc(1);
      n += int'(px_req);
    end
    check("line_gap_reqs", n, 0);
    cyc(1);
    check("line1_addr", 32'({px_req, px_addr}), 32'({1'b1, 19'd8}));
  endtask

  initial begin
    cyc(3);
    rst = 0;
    snap();
    cyc(50);
    check("idle_req", n_req - s_req, 0);
    check("idle_vis", n_vis - s_vis, 0);
    check("idle_hsync_low", n_hs - s_hs, 0);
    check("idle_vsync_low", n_vs - s_vs, 0);
    check("idle_underrun", 32'(underrun), 0);
    start_frame(0);
    cyc(46);
    sup = 1;
    push_frame(1);
    cyc(38);
    check("frame_req_count", n_req - s_req, 32);
    cyc(3);
    check("frame_vis_count", n_vis - s_vis, 32);
    check("frame_hsync_low", n_hs - s_hs, 14);
    check("frame_vsync_low", n_vs - s_vs, 14);
    check("vsync_line5_only", n_vsbad - s_vsbad, 0);
    check("frame_start_count", n_fs - s_fs, 1);
    cyc(4);
    check("underrun_before", 32'(underrun), 0);
    cyc(1);
    check("underrun_set", 32'(underrun), 1);
    cyc(44);
    sup = 0;
    push_frame(0);
    cyc(46);
    snap();
    cyc(30);
    enable = 0;
    cyc(68);
    check("drain_req_count", n_req - s_req, 32);
    check("underrun_sticky", n_u0 - s_u0, 0);
    cyc(2);
    check("stop_visible", 32'(dith_visible), 0);
    check("stop_syncs", 32'({hsync, vsync}), 3);
    check("stop_hcount", 32'(hcount), 0);
    s_req = n_req;
    cyc(40);
    check("stop_no_req", n_req - s_req, 0);
    start_frame(0);
    cyc(3);
    rst = 1;
    cyc(1);
    check("rst_req", 32'(px_req), 0);
    check("rst_vis_fs", 32'({dith_visible, frame_start}), 0);
    check("rst_rgb", 32'({dith_r, dith_g, dith_b}), 0);
    check("rst_syncs", 32'({hsync, vsync}), 3);
    check("rst_counts", 32'({hcount, vcount}), 0);
    check("rst_underrun", 32'(underrun), 0);
    rst = 0;
    q_addr.delete();
    q_pa.delete();
    q_rgb.delete();
    start_frame(0);
    enable = 0;
    cyc(100);
    check("queue_addr_empty", q_addr.size(), 0);
    check("queue_pix_empty", q_pa.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
